// File: rtl/l1_prefetch_unit.sv
// l1_prefetch_unit
//   Next-line instruction prefetcher. When a demand refill is accepted it
//   requests the following 16-byte line from the refill arbiter and keeps
//   the returned line in a single-entry buffer. The cache controller looks
//   up that buffer combinationally before issuing its own refill.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   enable_i                 allow new prefetches to start
//   flush_i                  invalidate buffer, discard any in-flight line
//   miss_valid_i/miss_addr_i demand refill accepted (one-cycle pulse)
//   pre_refill_req_o/_gnt_i  request/grant with the refill arbiter
//   pre_refill_addr_o        line-aligned prefetch address
//   pre_refill_r_valid_i/
//   pre_refill_r_data_i      single-beat line return
//   lookup_addr_i            controller lookup address
//   lookup_hit_o             buffer valid and line tag matches
//   lookup_data_o            buffered line
//   busy_o                   FSM not idle
//   stat_hits_o              saturating count of hit cycles
module l1_prefetch_unit #(
  parameter int unsigned FETCH_ADDR_WIDTH  = 32,
  parameter int unsigned REFILL_DATA_WIDTH = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable_i,
  input  logic                         flush_i,
  input  logic                         miss_valid_i,
  input  logic [FETCH_ADDR_WIDTH-1:0]  miss_addr_i,
  output logic                         pre_refill_req_o,
  input  logic                         pre_refill_gnt_i,
  output logic [FETCH_ADDR_WIDTH-1:0]  pre_refill_addr_o,
  input  logic                         pre_refill_r_valid_i,
  input  logic [REFILL_DATA_WIDTH-1:0] pre_refill_r_data_i,
  input  logic [FETCH_ADDR_WIDTH-1:0]  lookup_addr_i,
  output logic                         lookup_hit_o,
  output logic [REFILL_DATA_WIDTH-1:0] lookup_data_o,
  output logic                         busy_o,
  output logic [15:0]                  stat_hits_o
);

  localparam int unsigned TW = FETCH_ADDR_WIDTH - 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA
  } state_t;

  state_t                       r_state;
  logic [TW-1:0]                r_tag;
  logic [TW-1:0]                r_target;
  logic [REFILL_DATA_WIDTH-1:0] r_data;
  logic                         r_buf_valid;
  logic                         r_discard;
  logic                         r_req;
  logic                         r_busy;
  logic [FETCH_ADDR_WIDTH-1:0]  r_addr;
  logic [15:0]                  r_stat;

  logic [TW:0]                  w_next;
  logic                         w_carry;
  logic                         w_dup;
  logic                         w_hit;
  logic                         w_unused;

  // One extra bit catches the carry out of the last line of the address space.
  assign w_next   = {1'b0, miss_addr_i[FETCH_ADDR_WIDTH-1:4]} + {{TW{1'b0}}, 1'b1};
  assign w_carry  = w_next[TW];
  assign w_dup    = r_buf_valid && (r_tag == w_next[TW-1:0]);
  assign w_hit    = r_buf_valid && (r_tag == lookup_addr_i[FETCH_ADDR_WIDTH-1:4]);
  assign w_unused = ^{miss_addr_i[3:0], lookup_addr_i[3:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tag       <= '0;
      r_target    <= '0;
      r_data      <= '0;
      r_buf_valid <= 1'b0;
      r_discard   <= 1'b0;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_addr      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (miss_valid_i && enable_i && !w_carry && !w_dup) begin
            r_buf_valid <= 1'b0;
            r_target    <= w_next[TW-1:0];
            r_discard   <= 1'b0;
            r_addr      <= {w_next[TW-1:0], 4'h0};
            r_req       <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= REQ;
          end
        end
        REQ: begin
          // Request is held until granted regardless of flush or enable.
          if (pre_refill_gnt_i) begin
            r_req   <= 1'b0;
            r_state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (pre_refill_r_valid_i) begin
            if (!r_discard && !flush_i) begin
              r_data      <= pre_refill_r_data_i;
              r_tag       <= r_target;
              r_buf_valid <= 1'b1;
            end
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase

      // Placed last so flush overrides a capture in the same edge.
      if (flush_i) begin
        r_buf_valid <= 1'b0;
        if (r_state != IDLE) begin
          r_discard <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat <= '0;
    end else if (w_hit && (r_stat != '1)) begin
      r_stat <= r_stat + 16'd1;
    end
  end

  assign pre_refill_req_o  = r_req;
  assign pre_refill_addr_o = r_addr;
  assign lookup_hit_o      = w_hit;
  assign lookup_data_o     = r_data;
  assign busy_o            = r_busy;
  assign stat_hits_o       = r_stat;

endmodule

// File: doc/l1_prefetch_unit.md
# l1_prefetch_unit

Next-line instruction prefetcher for the L1 instruction cache. It observes demand refills issued by the cache controller, requests the following 16-byte line through the prefetch port of the refill arbiter, and holds the returned line in a single-entry prefetch buffer. The cache controller looks up this buffer before issuing a demand refill. The block sits directly upstream of the refill arbiter's `pre_refill_*` port.

## Interface
- FETCH_ADDR_WIDTH, 32, byte address width. The line offset is always bits [3:0].
- REFILL_DATA_WIDTH, 128, line width in bits (one 16-byte line).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable_i  in  1  prefetch enable. When low, no new prefetch starts.
- flush_i  in  1  invalidates the buffer and cancels in-flight data capture.
- miss_valid_i  in  1  one-cycle pulse: a demand refill was accepted.
- miss_addr_i  in  FETCH_ADDR_WIDTH  address of that demand refill.
- pre_refill_req_o  out  1  prefetch request to the arbiter.
- pre_refill_gnt_i  in  1  arbiter grant.
- pre_refill_addr_o  out  FETCH_ADDR_WIDTH  line-aligned prefetch address ([3:0] = 0).
- pre_refill_r_valid_i  in  1  prefetch data valid (single beat).
- pre_refill_r_data_i  in  REFILL_DATA_WIDTH  prefetch line data.
- lookup_addr_i  in  FETCH_ADDR_WIDTH  controller lookup address.
- lookup_hit_o  out  1  combinational: buffer valid and tag == lookup_addr_i[31:4].
- lookup_data_o  out  REFILL_DATA_WIDTH  buffered line. Always driven from the data register.
- busy_o  out  1  high when the FSM is not IDLE.
- stat_hits_o  out  16  saturating count of cycles in which lookup_hit_o was high.

## Operation
- Storage:
  - tag register [31:4]
  - data register
  - buf_valid flag
  - target register [31:4]
  - discard flag
- FSM states: IDLE, REQ, WAIT_DATA.
- IDLE: on `miss_valid_i & enable_i`, compute target = miss_addr_i[31:4] + 1.
  - If the increment carries out (the miss is in the last line of the address space), take no action.
  - If `buf_valid` and tag == target, the line is already buffered; take no action.
  - Otherwise: clear `buf_valid`, latch target, clear discard, go to REQ.
- REQ:
  - `pre_refill_req_o` = 1, `pre_refill_addr_o` = {target, 4'h0}.
  - The request is never withdrawn before grant, even on flush or when `enable_i` falls.
  - On `pre_refill_gnt_i`, go to WAIT_DATA.
- WAIT_DATA:
  - `pre_refill_req_o` = 0.
  - On `pre_refill_r_valid_i`:
    - If discard is clear: data register <= `pre_refill_r_data_i`, tag <= target, `buf_valid` <= 1.
    - If discard is set: drop the data.
  - In either case, go to IDLE.
- `miss_valid_i` outside IDLE is dropped. It is not queued.
- Flush:
  - Clears `buf_valid` in the same edge.
  - In REQ or WAIT_DATA, also sets discard, so the returning line is not stored.
  - Flush in the same cycle as `r_valid`: the data is discarded.
  - Flush has priority over capture.
- Lookup is purely combinational. A hit does not consume the entry; the entry stays until it is replaced or flushed.
- `stat_hits_o` increments on each cycle with `lookup_hit_o` = 1 and saturates at 16'hFFFF.
- Reset values:
  - FSM in IDLE.
  - `pre_refill_req_o` = 0, `pre_refill_addr_o` = 0.
  - `buf_valid` = 0, tag/target/data = 0, discard = 0.
  - `lookup_hit_o` = 0, `busy_o` = 0, `stat_hits_o` = 0.
- Reset mid-transaction returns to IDLE immediately. Any later `r_valid` is ignored.

## Timing
- Miss pulse in cycle N (IDLE) -> `pre_refill_req_o` high from N+1.
- Grant in cycle M -> `pre_refill_req_o` low from M+1. Grant is accepted in the same cycle it is first asserted.
- `r_valid` in cycle K -> `lookup_hit_o` can assert from K+1. FSM is in IDLE at K+1, so a miss at K+1 is accepted.
- The buffer is not readable during the capture cycle K itself.
- Minimum prefetch round trip: miss N, req N+1 with same-cycle grant, data N+2 at the earliest, hit N+3.
- `pre_refill_addr_o` is stable from entering REQ until the grant.

## Test plan
- Basic prefetch:
  - Stimulus: miss at 0x1000_0024; grant after 2 cycles; data 128'hA5..A5 after 3 more cycles.
  - Response: req with addr 0x1000_0030; after data, lookup 0x1000_003C hits with data 128'hA5..A5; `busy_o` low.
- Duplicate suppression:
  - Stimulus: with buffer holding line 0x1000_0030, miss at 0x1000_0020.
  - Response: no req; buffer and `stat_hits_o` unchanged.
- Flush in WAIT_DATA:
  - Stimulus: flush one cycle before `r_valid`.
  - Response: `lookup_hit_o` stays 0 for the returned line; FSM returns to IDLE.
- Address wrap:
  - Stimulus: miss at 0xFFFF_FFF8.
  - Response: no req; FSM stays IDLE.
- Dropped miss and mid-flight reset:
  - Stimulus: a second miss during REQ; then assert `rst` in WAIT_DATA and deliver `r_valid` after reset.
  - Response: only one req observed; after reset, all outputs are 0 and no capture occurs.
- Disable and counter:
  - Stimulus: `enable_i` = 0, then a miss; then hold a hitting lookup for 70000 cycles.
  - Response: no req for the disabled miss; `stat_hits_o` saturates at 16'hFFFF.
